fetch_queue: RTL

Dual-issue instruction queue between the fetch stage and the dual decode slots. Accepts up to two instructions per cycle from fetch and presents the two oldest entries to decode, which consumes 0, 1 or 2 per cycle. The number consumed depends on the intra-pair hazard and stall decisions made by the decode-stage control. Decouples fetch latency from issue stalls and supports a single-cycle flush on branch/jump redirect.

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types for the fetch queue and the decode stage.
//   u1/u32/u64    : basic unsigned scalar/vector types
//   fetch_entry_t : one queued instruction (pc + raw instruction word)
//   FQ_LANES      : instructions fetch can push per cycle
//   instrPc()     : PC of lane l within a fetch group
package fetch_queue_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef struct packed {
        u64 pc;
        u32 rawInstr;
    } fetch_entry_t;

    localparam int FQ_LANES = 2;

    // Instructions are 4 bytes, so lane l of a fetch group sits at pc + 4*l.
    function automatic u64 instrPc(input u64 basePc, input int lane);
        return basePc + 64'(lane) * 64'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue circular instruction queue between fetch and decode.
//   clk, reset          : clock, synchronous active-high reset
//   flush               : redirect, drops all entries (and any same-cycle push)
//   in_valid/in_two     : fetch push strobe; in_two marks the high instr valid
//   in_pc/in_instr      : low PC and the two raw instructions (low in [31:0])
//   in_ready            : room for a full pair, derived from registered count
//   out_valid0/1        : slot 0/1 hold the oldest/second-oldest entries
//   out_pc0/1, out_instr0/1 : slot contents, read combinationally from storage
//   deq_num             : entries decode consumes this cycle (clamped to count)
//   count               : current occupancy
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic                     in_two,
    input  logic [63:0]              in_pc,
    input  logic [63:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid0,
    output logic                     out_valid1,
    output logic [63:0]              out_pc0,
    output logic [63:0]              out_pc1,
    output logic [31:0]              out_instr0,
    output logic [31:0]              out_instr1,
    input  logic [1:0]               deq_num,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_entry_t         mem [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        cnt;

    // ------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------
    logic                 pushFire;
    logic [1:0]           pushNum;
    logic [FQ_LANES-1:0]  wrEn;
    logic [PW-1:0]        wrIdx   [FQ_LANES];
    fetch_entry_t         wrEntry [FQ_LANES];

    // Ready only looks at the registered count so it never forms a
    // combinational path from decode's deq_num back to fetch.
    assign in_ready = (cnt <= CW'(DEPTH - 2));
    assign pushFire = in_valid && in_ready && !flush;
    assign pushNum  = pushFire ? (in_two ? 2'd2 : 2'd1) : 2'd0;

    for (genvar l = 0; l < FQ_LANES; l++) begin : gWrLane
        // Pointer arithmetic wraps for free since DEPTH is a power of two.
        assign wrIdx[l]            = tail + PW'(l);
        assign wrEntry[l].pc       = instrPc(in_pc, l);
        assign wrEntry[l].rawInstr = in_instr[32*l +: 32];
        assign wrEn[l]             = pushFire && (l == 0 || in_two);
    end

    // Storage has no reset: stale entries are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        for (int l = 0; l < FQ_LANES; l++) begin
            if (wrEn[l] && !reset) begin
                mem[wrIdx[l]] <= wrEntry[l];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pop side
    // ------------------------------------------------------------------
    logic [1:0] deqEff;
    logic [1:0] popNum;

    always_comb begin
        deqEff = (deq_num == 2'd3) ? 2'd2 : deq_num;
        popNum = deqEff;
        // deqEff <= 2, so whenever it exceeds cnt the low bits of cnt are exact.
        if (CW'(deqEff) > cnt) begin
            popNum = cnt[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Pointer / occupancy update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(popNum);
            tail <= tail + PW'(pushNum);
            cnt  <= cnt + CW'(pushNum) - CW'(popNum);
        end
    end

    // ------------------------------------------------------------------
    // Slot outputs
    // ------------------------------------------------------------------
    logic [PW-1:0] rdIdx1;
    fetch_entry_t  slot0;
    fetch_entry_t  slot1;

    assign rdIdx1     = head + PW'(1);
    assign slot0      = mem[head];
    assign slot1      = mem[rdIdx1];

    assign out_valid0 = (cnt >= CW'(1));
    assign out_valid1 = (cnt >= CW'(2));
    assign out_pc0    = slot0.pc;
    assign out_instr0 = slot0.rawInstr;
    assign out_pc1    = slot1.pc;
    assign out_instr1 = slot1.rawInstr;
    assign count      = cnt;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    aDeqLegal: assert property (@(posedge clk) disable iff (reset) deq_num != 2'd3)
        else $error("fetch_queue: deq_num=3 is illegal");
    aDeqInRange: assert property (@(posedge clk) disable iff (reset) CW'(deq_num) <= cnt)
        else $error("fetch_queue: deq_num exceeds occupancy");
`endif

endmodule
